onehot_encoder_serializer: RTL and testbench

- Converts request vectors back into binary indices; it is the encoder counterpart to the team's 2-to-4 enable decoder.
- Accepts a multi-hot N-bit vector over a valid/ready handshake.
- Emits the binary index of each set bit, lowest index first, one per handshake beat, with a last flag on the final beat.
- Sits between request-generating logic and decoder-driven consumers: feeding every emitted index through the decoder reproduces the original vector bits.

---
 rtl/onehot_encoder_serializer.sv | 152 +++++++++++++++
 tb/tb_onehot_encoder_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_serializer.sv
// onehot_encoder_serializer
//
// Takes a multi-hot request vector over a valid/ready handshake and returns
// the binary index of every set bit, lowest index first, one index per
// output beat. The final beat of a vector carries out_last. Sending each
// emitted index through the 2-to-4 enable decoder rebuilds the original
// vector, one bit per beat.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   en         block enable; low blocks acceptance and aborts any vector
//              still being emitted
//   in_vld     in_vec is valid
//   in_rdy     block can accept a vector this cycle
//   in_vec     N-bit request vector, more than one bit may be set
//   out_vld    out_idx / out_last are valid
//   out_rdy    consumer takes the current beat
//   out_idx    binary index of the lowest pending set bit
//   out_last   current beat is the final beat of the vector
//   zero_pulse one-cycle pulse after an all-zero vector was accepted and
//              dropped
//   busy       high while the block is emitting beats

module onehot_encoder_serializer #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [N-1:0]     in_vec,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_pulse,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     pending;
  logic [N-1:0]     pending_nxt;
  logic             zero_nxt;
  logic [N-1:0]     low_mask;
  logic [IDX_W-1:0] low_idx;
  logic             single;
  logic             accept;

  // Isolate the lowest set bit of the pending vector. Adding one to the
  // inverted vector carries up to exactly that bit, so the AND leaves it
  // alone. Clearing this mask is how a delivered beat is retired.
  always_comb begin
    low_mask = pending & (~pending + N'(1));
  end

  // Binary position of the lowest set bit. The loop walks from the top down
  // so the last match to win is the lowest index. An empty vector gives 0,
  // which keeps out_idx at 0 whenever nothing is pending.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // Exactly one bit pending means the current beat is the final one.
  // Clearing the lowest set bit and getting zero is the power-of-two test.
  always_comb begin
    single = (pending != '0) && ((pending & (pending - N'(1))) == '0);
  end

  // The handshake is ready only in IDLE with the block enabled. rst is
  // folded in so in_rdy drops at the moment reset is asserted, without
  // waiting for the state register to settle.
  always_comb begin
    in_rdy = en && (state == IDLE) && !rst;
    accept = in_vld && in_rdy;
  end

  // Next-state and next-pending logic. An all-zero vector is accepted but
  // produces no beats, so it only raises zero_pulse for the following
  // cycle. Dropping en during EMIT throws away what remains. A beat that
  // handshakes on that same edge has already been seen by the consumer, so
  // nothing extra is done for it.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    zero_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_vec == '0) begin
            zero_nxt = 1'b1;
          end else begin
            pending_nxt = in_vec;
            state_nxt   = EMIT;
          end
        end
      end
      EMIT: begin
        if (!en) begin
          pending_nxt = '0;
          state_nxt   = IDLE;
        end else if (out_rdy) begin
          pending_nxt = pending & ~low_mask;
          if (single) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        pending_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // State, pending vector and the zero pulse flop. Reset clears everything
  // asynchronously so all outputs fall to their idle values immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      zero_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      zero_pulse <= zero_nxt;
    end
  end

  // Output beats come only from registered state, so they stay stable while
  // the consumer stalls. Outside EMIT everything is held at zero.
  always_comb begin
    out_vld  = (state == EMIT);
    busy     = (state == EMIT);
    out_idx  = (state == EMIT) ? low_idx : '0;
    out_last = (state == EMIT) && single;
  end

endmodule

// File: tb/tb_onehot_encoder_serializer.sv
// tb_onehot_encoder_serializer
//
// Table-driven bench for onehot_encoder_serializer with N=4, IDX_W=2.
// Inputs are driven and outputs sampled on the falling clock edge. Each
// table record holds a vector and the beats expected from it. Hand-written
// sequences cover stalls, zero vectors, enable abort and async reset.

module tb_onehot_encoder_serializer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_vld;
  logic       in_rdy;
  logic [3:0] in_vec;
  logic       out_vld;
  logic       out_rdy;
  logic [1:0] out_idx;
  logic       out_last;
  logic       zero_pulse;
  logic       busy;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] vec;
    int         nbeats;
    logic [1:0] idxs [4];
  } vec_rec_t;

  vec_rec_t table_q [$];

  onehot_encoder_serializer #(
    .N     (4),
    .IDX_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_vec     (in_vec),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .zero_pulse (zero_pulse),
    .busy       (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic e, input logic v, input logic [3:0] vec,
                               input logic r);
    en      = e;
    in_vld  = v;
    in_vec  = vec;
    out_rdy = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Checks every output against its idle value and in_rdy against rdy_exp.
  task automatic checkIdle(input string tag, input logic rdy_exp);
    checkOutput({tag, " out_vld"}, 32'(out_vld), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " out_idx"}, 32'(out_idx), 32'd0);
    checkOutput({tag, " out_last"}, 32'(out_last), 32'd0);
    checkOutput({tag, " in_rdy"}, 32'(in_rdy), 32'(rdy_exp));
  endtask

  task automatic checkBeat(input string tag, input logic [1:0] idx, input logic last);
    checkOutput({tag, " out_vld"}, 32'(out_vld), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " out_idx"}, 32'(out_idx), 32'(idx));
    checkOutput({tag, " out_last"}, 32'(out_last), 32'(last));
    checkOutput({tag, " in_rdy"}, 32'(in_rdy), 32'd0);
  endtask

  task automatic addRec(input logic [3:0] vec, input int n, input logic [1:0] i0,
                        input logic [1:0] i1, input logic [1:0] i2, input logic [1:0] i3);
    vec_rec_t r;
    r.vec     = vec;
    r.nbeats  = n;
    r.idxs[0] = i0;
    r.idxs[1] = i1;
    r.idxs[2] = i2;
    r.idxs[3] = i3;
    table_q.push_back(r);
  endtask

  initial begin
    logic [3:0] decoded;
    checks = 0;
    errors = 0;

    addRec(4'b1011, 3, 2'd0, 2'd1, 2'd3, 2'd0);
    addRec(4'b0001, 1, 2'd0, 2'd0, 2'd0, 2'd0);
    addRec(4'b0010, 1, 2'd1, 2'd0, 2'd0, 2'd0);
    addRec(4'b0100, 1, 2'd2, 2'd0, 2'd0, 2'd0);
    addRec(4'b1000, 1, 2'd3, 2'd0, 2'd0, 2'd0);
    addRec(4'b1111, 4, 2'd0, 2'd1, 2'd2, 2'd3);
    addRec(4'b1010, 2, 2'd1, 2'd3, 2'd0, 2'd0);

    // Reset state with en already high: in_rdy must still be low.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    #2;
    checkIdle("reset", 1'b0);
    checkOutput("reset zero_pulse", 32'(zero_pulse), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_rdy", 32'(in_rdy), 32'd1);

    // Table: accept each vector with out_rdy high and collect its beats.
    // Each emitted index is decoded as the 2-to-4 decoder would do it, and
    // the rebuilt vector must match the original.
    foreach (table_q[t]) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, table_q[t].vec, 1'b1);
      decoded = 4'b0000;
      for (int b = 0; b < table_q[t].nbeats; b++) begin
        @(negedge clk);
        in_vld = 1'b0;
        checkBeat($sformatf("vec%b beat%0d", table_q[t].vec, b),
                  table_q[t].idxs[b], (b == table_q[t].nbeats - 1));
        if (out_vld) decoded = decoded | (4'b0001 << out_idx);
      end
      @(negedge clk);
      checkIdle($sformatf("vec%b done", table_q[t].vec), 1'b1);
      checkOutput($sformatf("vec%b decoded", table_q[t].vec), 32'(decoded),
                  32'(table_q[t].vec));
    end

    // Stall: the first beat must hold for three cycles while out_rdy is low.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'b0110, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_vld = 1'b0;
      checkBeat($sformatf("stall hold%0d", c), 2'd1, 1'b0);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    checkBeat("stall second", 2'd2, 1'b1);
    @(negedge clk);
    checkIdle("stall done", 1'b1);

    // Zero vector: one zero_pulse, no beat.
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    in_vld = 1'b0;
    checkOutput("zero pulse", 32'(zero_pulse), 32'd1);
    checkIdle("zero c1", 1'b1);
    @(negedge clk);
    checkOutput("zero pulse end", 32'(zero_pulse), 32'd0);
    checkIdle("zero c2", 1'b1);

    // With en low, in_vld is ignored for both zero and nonzero vectors.
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("en0 zero no pulse", 32'(zero_pulse), 32'd0);
    checkIdle("en0 zero", 1'b0);
    in_vec = 4'b0101;
    @(negedge clk);
    checkIdle("en0 nonzero", 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    #1;
    checkOutput("en1 in_rdy", 32'(in_rdy), 32'd1);

    // Enable abort after two beats of 1111.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b1);
    @(negedge clk);
    in_vld = 1'b0;
    checkBeat("abort beat0", 2'd0, 1'b0);
    @(negedge clk);
    checkBeat("abort beat1", 2'd1, 1'b0);
    en = 1'b0;
    @(negedge clk);
    checkIdle("abort c1", 1'b0);
    @(negedge clk);
    checkIdle("abort c2", 1'b0);
    en = 1'b1;
    #1;
    checkOutput("abort en back in_rdy", 32'(in_rdy), 32'd1);

    // Async reset in the middle of EMIT, between clock edges.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0);
    @(negedge clk);
    in_vld = 1'b0;
    checkBeat("prerst", 2'd0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkIdle("async rst", 1'b0);
    checkOutput("async rst zero_pulse", 32'(zero_pulse), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    out_rdy = 1'b1;
    #1;
    checkOutput("rst release in_rdy", 32'(in_rdy), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'b1000, 1'b1);
    @(negedge clk);
    in_vld = 1'b0;
    checkBeat("postrst beat", 2'd3, 1'b1);
    @(negedge clk);
    checkIdle("postrst done", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
